uparc_radix_idiv: RTL and testbench

Parametrised iterative integer divider for the uParc CPU execution stage. It is the successor to the single-bit long divider, generalised in operand width and in quotient bits retired per cycle. It uses valid/ready handshakes on both input and output and reports divide-by-zero explicitly. Computes signed or unsigned quotient and remainder, truncating toward zero, and supports abort on pipeline flush.

---
 rtl/uparc_radix_idiv.sv | 145 ++++++++++++++
 tb/tb_uparc_radix_idiv.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uparc_radix_idiv.sv
// Iterative restoring integer divider (signed/unsigned, truncating toward zero)
// retiring BPC quotient bits per cycle, with valid/ready handshakes and flush abort.
module uparc_radix_idiv #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signd,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (!(BPC == 1 || BPC == 2 || BPC == 4) || (WIDTH % BPC) != 0 ||
            WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_params
            $error("uparc_radix_idiv: illegal WIDTH/BPC combination");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   diff;
    logic             ge;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // abs(INT_MIN) wraps to 2^(WIDTH-1), which is exactly the unsigned magnitude.
    always_comb begin
        dividend_abs = (signd && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_abs  = (signd && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        rem_nx = rem_r;
        quo_nx = quo_r;
        sh     = '0;
        diff   = '0;
        ge     = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            sh     = {rem_nx, quo_nx[WIDTH-1]};
            diff   = sh - {1'b0, dvs_r};
            ge     = (sh >= {1'b0, dvs_r});
            rem_nx = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
            quo_nx = {quo_nx[WIDTH-2:0], ge};
        end
        q_fix = neg_q ? -quo_nx : quo_nx;
        r_fix = neg_r ? -rem_nx : rem_nx;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                            state     <= S_DONE;
                        end else if (dividend == '0) begin
                            quotient  <= '0;
                            remainder <= '0;
                            div_zero  <= 1'b0;
                            state     <= S_DONE;
                        end else begin
                            rem_r <= '0;
                            quo_r <= dividend_abs;
                            dvs_r <= divisor_abs;
                            neg_q <= signd && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r <= signd && dividend[WIDTH-1];
                            cnt   <= CW'(N);
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        rem_r <= rem_nx;
                        quo_r <= quo_nx;
                        cnt   <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            quotient  <= q_fix;
                            remainder <= r_fix;
                            div_zero  <= 1'b0;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (abort || out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uparc_radix_idiv.sv
// Directed bench for uparc_radix_idiv: three instances (BPC=1,2,4) share stimulus
// so results and per-radix latencies are checked side by side.
module tb_uparc_radix_idiv;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        signd;
    logic        abort;
    logic        out_ready;

    logic        rdy1, rdy2, rdy4;
    logic        ov1, ov2, ov4;
    logic [31:0] q1, q2, q4;
    logic [31:0] r1, r2, r4;
    logic        dz1, dz2, dz4;

    int tests_run;
    int tests_failed;

    int          lat1, lat2, lat4;
    logic [31:0] cq1, cq2, cq4, cr1, cr2, cr4;
    logic        cdz1, cdz2, cdz4;

    uparc_radix_idiv #(.WIDTH(32), .BPC(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .dividend(dividend), .divisor(divisor), .signd(signd), .abort(abort),
        .out_valid(ov1), .out_ready(out_ready), .quotient(q1), .remainder(r1),
        .div_zero(dz1)
    );

    uparc_radix_idiv #(.WIDTH(32), .BPC(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .dividend(dividend), .divisor(divisor), .signd(signd), .abort(abort),
        .out_valid(ov2), .out_ready(out_ready), .quotient(q2), .remainder(r2),
        .div_zero(dz2)
    );

    uparc_radix_idiv #(.WIDTH(32), .BPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .dividend(dividend), .divisor(divisor), .signd(signd), .abort(abort),
        .out_valid(ov4), .out_ready(out_ready), .quotient(q4), .remainder(r4),
        .div_zero(dz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepts one operation on all three instances and records, per instance,
    // the edge count (accept edge = 1) at which out_valid appears and the result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic ab);
        int cyc;
        cyc = 0;
        while (!(rdy1 && rdy2 && rdy4) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!(rdy1 && rdy2 && rdy4)) begin
            tests_run++;
            tests_failed++;
            $display("FAIL run_op_ready_timeout: in_ready=%b%b%b required 111", rdy1, rdy2, rdy4);
        end
        dividend = a;
        divisor  = b;
        signd    = s;
        abort    = ab;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0005;
        signd    = ~s;
        lat1 = 0; lat2 = 0; lat4 = 0;
        cyc = 1;
        while (cyc <= 60) begin
            if (ov1 && lat1 == 0) begin lat1 = cyc; cq1 = q1; cr1 = r1; cdz1 = dz1; end
            if (ov2 && lat2 == 0) begin lat2 = cyc; cq2 = q2; cr2 = r2; cdz2 = dz2; end
            if (ov4 && lat4 == 0) begin lat4 = cyc; cq4 = q4; cr4 = r4; cdz4 = dz4; end
            if (lat1 != 0 && lat2 != 0 && lat4 != 0) break;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [31:0] eq,
                                input logic [31:0] er, input logic edz,
                                input int el1, input int el2, input int el4);
        tests_run++;
        if (cq1 !== eq || cq2 !== eq || cq4 !== eq) begin
            tests_failed++;
            $display("FAIL %s_quotient: got %h/%h/%h required %h", name, cq1, cq2, cq4, eq);
        end
        tests_run++;
        if (cr1 !== er || cr2 !== er || cr4 !== er) begin
            tests_failed++;
            $display("FAIL %s_remainder: got %h/%h/%h required %h", name, cr1, cr2, cr4, er);
        end
        tests_run++;
        if (cdz1 !== edz || cdz2 !== edz || cdz4 !== edz) begin
            tests_failed++;
            $display("FAIL %s_div_zero: got %b/%b/%b required %b", name, cdz1, cdz2, cdz4, edz);
        end
        tests_run++;
        if (lat1 != el1 || lat2 != el2 || lat4 != el4) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d/%0d/%0d required %0d/%0d/%0d",
                     name, lat1, lat2, lat4, el1, el2, el4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; dividend = '0; divisor = '0; signd = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({rdy1, rdy2, rdy4, ov1, ov2, ov4, dz1, dz2, dz4} !== 9'b111_000_000 ||
            q1 !== 32'h0 || r1 !== 32'h0 || q4 !== 32'h0 || r4 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: rdy=%b%b%b ov=%b%b%b dz=%b%b%b q1=%h r1=%h required rdy=111 ov=000 dz=000 q=r=0",
                     rdy1, rdy2, rdy4, ov1, ov2, ov4, dz1, dz2, dz4, q1, r1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        run_op(32'd100, 32'd7, 1'b0, 1'b0);
        check_result("u100_7", 32'd14, 32'd2, 1'b0, 33, 17, 9);
        consume();
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
        check_result("uffff_10", 32'h0FFF_FFFF, 32'hF, 1'b0, 33, 17, 9);
        consume();
    endtask

    task automatic test_signed();
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        check_result("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 17, 9);
        consume();
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        check_result("s_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 17, 9);
        consume();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check_result("s_intmin_m1", 32'h8000_0000, 32'h0, 1'b0, 33, 17, 9);
        consume();
    endtask

    task automatic test_shortcuts();
        run_op(32'h1234, 32'h0, 1'b1, 1'b0);
        check_result("divzero", 32'hFFFF_FFFF, 32'h1234, 1'b1, 1, 1, 1);
        consume();
        run_op(32'h0, 32'd5, 1'b0, 1'b0);
        check_result("zero_dividend", 32'h0, 32'h0, 1'b0, 1, 1, 1);
        consume();
    endtask

    task automatic test_backpressure();
        run_op(32'd100, 32'd7, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (!ov1 || rdy1 || q1 !== 32'd14 || r1 !== 32'd2 || dz1 !== 1'b0 ||
                !ov4 || rdy4 || q4 !== 32'd14) begin
                tests_failed++;
                $display("FAIL backpressure_hold_%0d: ov1=%b rdy1=%b q1=%h r1=%h ov4=%b rdy4=%b q4=%h required ov=1 rdy=0 q=0000000e r=00000002",
                         i, ov1, rdy1, q1, r1, ov4, rdy4, q4);
            end
        end
        consume();
        tests_run++;
        if (ov1 || ov2 || ov4 || !rdy1 || !rdy2 || !rdy4 || q1 !== 32'd14 || r1 !== 32'd2) begin
            tests_failed++;
            $display("FAIL consume_idle: ov=%b%b%b rdy=%b%b%b q1=%h r1=%h required ov=000 rdy=111 q1=0000000e r1=00000002",
                     ov1, ov2, ov4, rdy1, rdy2, rdy4, q1, r1);
        end
    endtask

    task automatic test_abort();
        dividend = 32'd1000; divisor = 32'd3; signd = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        // BPC=4 instance is already in DONE here; abort must beat out_ready.
        abort = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (ov1 || ov2 || ov4 || !rdy1 || !rdy2 || !rdy4) begin
            tests_failed++;
            $display("FAIL abort_to_idle: ov=%b%b%b rdy=%b%b%b required ov=000 rdy=111",
                     ov1, ov2, ov4, rdy1, rdy2, rdy4);
        end
        repeat (30) @(posedge clk);
        #1;
        tests_run++;
        if (ov1 || ov2 || ov4) begin
            tests_failed++;
            $display("FAIL abort_no_result: ov=%b%b%b required 000", ov1, ov2, ov4);
        end
        // abort is ignored in IDLE, so this accept still happens
        run_op(32'd9, 32'd3, 1'b0, 1'b1);
        check_result("after_abort_9_3", 32'd3, 32'd0, 1'b0, 33, 17, 9);
        consume();
    endtask

    task automatic test_reset_mid_run();
        dividend = 32'd1000; divisor = 32'd7; signd = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (!rdy1 || !rdy2 || !rdy4 || ov1 || ov2 || ov4 || q1 !== 32'h0 || r1 !== 32'h0 ||
            q2 !== 32'h0 || r4 !== 32'h0 || dz1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: rdy=%b%b%b ov=%b%b%b q1=%h r1=%h q2=%h r4=%h required rdy=111 ov=000 q=r=0",
                     rdy1, rdy2, rdy4, ov1, ov2, ov4, q1, r1, q2, r4);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(32'd15, 32'd4, 1'b0, 1'b0);
        check_result("post_reset_15_4", 32'd3, 32'd3, 1'b0, 33, 17, 9);
        consume();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_shortcuts();
        test_backpressure();
        test_abort();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
